// File: rtl/fp32_divider_seq.sv
// Multi-cycle FP32 divider: restoring mantissa division, normalisation, range check, valid/ready handoff.
// Optional build macro ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fp32_divider_seq #(
  parameter int unsigned BIAS  = 127,
  parameter int unsigned QBITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_invalid,
  output logic        flag_div_zero,
  output logic        flag_overflow,
  output logic        flag_underflow
);

  localparam int unsigned EW = 10;
  localparam int unsigned CW = 5;
  localparam int unsigned MW = 24;
  localparam int unsigned RW = 25;

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

  state_t               r_state;
  logic                 r_sign;
  logic signed [EW-1:0] r_exp;
  logic [MW-1:0]        r_div;
  logic [RW-1:0]        r_rem;
  logic [QBITS-1:0]     r_q;
  logic [CW-1:0]        r_cnt;
  logic                 r_out_valid;
  logic [31:0]          r_result;
  logic                 r_inv, r_dz, r_ovf, r_unf;

  // Operand classification; denormals count as zero
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_ma, w_mb;
  logic        w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic        w_sign;
  logic signed [EW-1:0] w_exp_in;

  assign w_ea     = a[30:23];
  assign w_ma     = a[22:0];
  assign w_eb     = b[30:23];
  assign w_mb     = b[22:0];
  assign w_a_zero = (w_ea == 8'h00);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_ma == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_ma != 23'd0);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_mb == 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_mb != 23'd0);
  assign w_sign   = a[31] ^ b[31];
  assign w_exp_in = EW'({2'b00, w_ea}) - EW'({2'b00, w_eb}) + EW'(BIAS);

  logic        w_special, w_sp_inv, w_sp_dz;
  logic [31:0] w_sp_result;

  always_comb begin
    w_special   = 1'b1;
    w_sp_inv    = 1'b0;
    w_sp_dz     = 1'b0;
    w_sp_result = 32'd0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_sp_result = 32'h7FC0_0000;
      w_sp_inv    = 1'b1;
    end else if (w_a_inf) begin
      w_sp_result = {w_sign, 8'hFF, 23'd0};
    end else if (w_b_zero) begin
      w_sp_result = {w_sign, 8'hFF, 23'd0};
      w_sp_dz     = 1'b1;
    end else if (w_a_zero || w_b_inf) begin
      w_sp_result = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // One restoring step: subtract divisor when it fits, then shift the partial remainder
  logic          w_ge;
  logic [RW-1:0] w_sub;

  assign w_ge  = (r_rem >= {1'b0, r_div});
  assign w_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

  logic                 w_hi;
  logic [22:0]          w_frac, w_frac_f;
  logic signed [EW-1:0] w_exp_n, w_exp_f;
  logic [31:0]          w_norm_result;
  logic                 w_norm_ovf, w_norm_unf;

  assign w_hi    = r_q[QBITS-1];
  assign w_frac  = w_hi ? r_q[QBITS-2:2] : r_q[QBITS-3:1];
  assign w_exp_n = w_hi ? r_exp : (r_exp - EW'(1));

`ifdef ROUND_NEAREST_EN
  logic        w_guard, w_sticky, w_inc;
  logic [23:0] w_frac_sum;

  assign w_guard    = w_hi ? r_q[1] : r_q[0];
  assign w_sticky   = (w_hi & r_q[0]) | (r_rem != '0);
  assign w_inc      = w_guard & (w_sticky | w_frac[0]);
  assign w_frac_sum = {1'b0, w_frac} + 24'(w_inc);
  assign w_frac_f   = w_frac_sum[22:0];
  assign w_exp_f    = w_exp_n + EW'(w_frac_sum[23]);
`else
  assign w_frac_f = w_frac;
  assign w_exp_f  = w_exp_n;
`endif

  always_comb begin
    w_norm_ovf    = 1'b0;
    w_norm_unf    = 1'b0;
    w_norm_result = {r_sign, w_exp_f[7:0], w_frac_f};
    if (w_exp_f >= 10'sd255) begin
      w_norm_result = {r_sign, 8'hFF, 23'd0};
      w_norm_ovf    = 1'b1;
    end else if (w_exp_f <= 10'sd0) begin
      w_norm_result = {r_sign, 31'd0};
      w_norm_unf    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_div       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= 32'd0;
      r_inv       <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign <= w_sign;
            r_exp  <= w_exp_in;
            r_div  <= {1'b1, w_mb};
            r_rem  <= {2'b01, w_ma};
            r_q    <= '0;
            r_cnt  <= '0;
            if (w_special) begin
              r_result    <= w_sp_result;
              r_inv       <= w_sp_inv;
              r_dz        <= w_sp_dz;
              r_ovf       <= 1'b0;
              r_unf       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          r_q   <= {r_q[QBITS-2:0], w_ge};
          r_rem <= w_sub << 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(QBITS - 1)) r_state <= S_NORM;
        end
        S_NORM: begin
          r_result    <= w_norm_result;
          r_inv       <= 1'b0;
          r_dz        <= 1'b0;
          r_ovf       <= w_norm_ovf;
          r_unf       <= w_norm_unf;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_inv       <= 1'b0;
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready       = (r_state == S_IDLE);
  assign out_valid      = r_out_valid;
  assign result         = r_result;
  assign flag_invalid   = r_inv;
  assign flag_div_zero  = r_dz;
  assign flag_overflow  = r_ovf;
  assign flag_underflow = r_unf;

endmodule

// File: tb/tb_fp32_divider_seq.sv
// Directed bench for fp32_divider_seq: normal divides, special operands, range limits,
// backpressure and asynchronous reset during a divide.
module tb_fp32_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_invalid, flag_div_zero, flag_overflow, flag_underflow;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_INV  = 4'b1000;
  localparam logic [3:0] F_DZ   = 4'b0100;
  localparam logic [3:0] F_OVF  = 4'b0010;
  localparam logic [3:0] F_UNF  = 4'b0001;

  fp32_divider_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .flag_invalid   (flag_invalid),
    .flag_div_zero  (flag_div_zero),
    .flag_overflow  (flag_overflow),
    .flag_underflow (flag_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {flag_invalid, flag_div_zero, flag_overflow, flag_underflow};
  endfunction

  // Counts cycles from the accept edge (accept cycle = 1) until out_valid is seen
  task automatic wait_valid(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " out_valid timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " flags clear"}, 32'(flags()), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] er, input logic [3:0] ef, input int elat);
    int lat;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = ia; b = ib;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(tag, lat);
    check({tag, " result"}, result, er);
    check({tag, " flags"}, 32'(flags()), 32'(ef));
    check({tag, " latency"}, 32'(lat), 32'(elat));
    consume(tag);
  endtask

  initial begin
    int lat;
    logic [31:0] third;
`ifdef ROUND_NEAREST_EN
    third = 32'h3EAA_AAAB;
`else
    third = 32'h3EAA_AAAA;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", 32'(flags()), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("6/2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 28);
    run_op("1/3",      32'h3F80_0000, 32'h4040_0000, third,         F_NONE, 28);
    run_op("-6/2",     32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, F_NONE, 28);
    run_op("1/0",      32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, F_DZ,   1);
    run_op("-1/0",     32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, F_DZ,   1);
    run_op("0/0",      32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, F_INV,  1);
    run_op("nan/2",    32'h7FC0_0001, 32'h4000_0000, 32'h7FC0_0000, F_INV,  1);
    run_op("inf/inf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, F_INV,  1);
    run_op("inf/2",    32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, F_NONE, 1);
    run_op("2/-inf",   32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, F_NONE, 1);
    run_op("0/2",      32'h0000_0000, 32'h4000_0000, 32'h0000_0000, F_NONE, 1);
    run_op("denorm/1", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, F_NONE, 1);
    run_op("ovf",      32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, F_OVF,  28);
    run_op("unf",      32'h0080_0000, 32'h4000_0000, 32'h0000_0000, F_UNF,  28);

    // Backpressure: new operands offered while the result waits
    in_valid = 1'b1; a = 32'h40C0_0000; b = 32'h4000_0000;
    @(posedge clk); #1;
    a = 32'h3F80_0000; b = 32'h0000_0000;
    wait_valid("bp", lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp result stable", result, 32'h4040_0000);
      check("bp in_ready low", 32'(in_ready), 32'd0);
      check("bp out_valid held", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp handoff out_valid", 32'(out_valid), 32'd0);
    check("bp handoff in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next accepted", 32'(out_valid), 32'd1);
    check("bp next result", result, 32'h7F80_0000);
    check("bp next flags", 32'(flags()), 32'(F_DZ));
    consume("bp next");

    // Asynchronous reset in the middle of a divide
    run_op("pre-rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 28);
    in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h4040_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", result, 32'd0);
    check("rst flags", 32'(flags()), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post-rst", 32'h3F80_0000, 32'h4040_0000, third, F_NONE, 28);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
